complex_issue_queue: RTL and testbench

- Issue queue for the multi-cycle DIV/MOD functional unit; sits between rename/dispatch and the complex FU.
- Buffers up to DEPTH dispatched complex ops and tracks source-operand readiness via wakeup broadcasts.
- Each cycle, issues the oldest entry whose operands are both ready.
- Issued info is held in a registered output stage; the FU reads the PRF from its rj/rk indices.

---
 rtl/complex_issue_queue_pkg.sv | 43 ++++
 rtl/ciq_select.sv | 21 ++
 rtl/complex_issue_queue.sv | 170 +++++++++++++++++
 tb/tb_complex_issue_queue.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/complex_issue_queue_pkg.sv
// Shared types and opcode constants for the complex (DIV/MOD) issue queue.
package complex_issue_queue_pkg;

  localparam int PREG_INDEX_WIDTH      = 6;
  localparam int ROB_ENTRY_INDEX_WIDTH = 6;

  localparam logic [3:0] GENERAL_OPTYPE_ALU    = 4'd0;
  localparam logic [3:0] GENERAL_OPTYPE_BRANCH = 4'd1;
  localparam logic [3:0] GENERAL_OPTYPE_MEM    = 4'd2;
  localparam logic [3:0] GENERAL_OPTYPE_MUL    = 4'd3;
  localparam logic [3:0] GENERAL_OPTYPE_DIV    = 4'd4;

  localparam logic [4:0] _3R_DIV_W  = 5'd0;
  localparam logic [4:0] _3R_MOD_W  = 5'd1;
  localparam logic [4:0] _3R_DIV_WU = 5'd2;
  localparam logic [4:0] _3R_MOD_WU = 5'd3;

  typedef logic [PREG_INDEX_WIDTH-1:0]      preg_t;
  typedef logic [ROB_ENTRY_INDEX_WIDTH-1:0] rob_idx_t;

  typedef struct packed {
    rob_idx_t   rob_entry_index;
    preg_t      preg_rj;
    preg_t      preg_rk;
    preg_t      preg_rd;
    logic       rj_ready;
    logic       rk_ready;
    logic       rd_exist;
    logic [3:0] gen_op_type;
    logic [4:0] spec_op_type;
  } complex_iq_dispatch_info_t;

  typedef struct packed {
    rob_idx_t   rob_entry_index;
    preg_t      preg_rj;
    preg_t      preg_rk;
    preg_t      preg_rd;
    logic [3:0] gen_op_type;
    logic [4:0] spec_op_type;
    logic       rd_exist;
  } complex_issue_queue_issued_info_t;

endpackage

// File: rtl/ciq_select.sv
// Priority picker: lowest-index set bit of ready_i as one-hot and binary index.
module ciq_select #(
  parameter int DEPTH = 8
) (
  input  logic [DEPTH-1:0]         ready_i,
  output logic                     valid_o,
  output logic [DEPTH-1:0]         onehot_o,
  output logic [$clog2(DEPTH)-1:0] idx_o
);
  localparam int IDX_W = $clog2(DEPTH);

  always_comb begin
    valid_o  = |ready_i;
    onehot_o = ready_i & (~ready_i + DEPTH'(1));
    idx_o    = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ready_i[i]) idx_o = IDX_W'(i);
    end
  end

endmodule

// File: rtl/complex_issue_queue.sv
// Collapsing issue queue for the DIV/MOD unit; oldest-ready-first select, registered issue.
// Optional perf counters enabled by defining COMPLEX_IQ_PERF_CNT_EN.
module complex_issue_queue
  import complex_issue_queue_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int WAKEUP_PORTS = 4
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     flush,
  input  logic                                     dispatch_valid,
  output logic                                     dispatch_ready,
  input  complex_iq_dispatch_info_t                dispatch_info,
  input  logic [WAKEUP_PORTS-1:0]                  wakeup_valid,
  input  logic [WAKEUP_PORTS*PREG_INDEX_WIDTH-1:0] wakeup_preg,
  input  logic                                     fu_ready,
  output complex_issue_queue_issued_info_t         issued_info,
  output logic                                     issue_valid,
  output logic [$clog2(DEPTH+1)-1:0]               iq_count
`ifdef COMPLEX_IQ_PERF_CNT_EN
  ,
  output logic [31:0]                              perf_full_cycles,
  output logic [31:0]                              perf_issue_cnt
`endif
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = $clog2(DEPTH);

  function automatic logic woken(input preg_t p,
                                 input logic [WAKEUP_PORTS-1:0] v,
                                 input logic [WAKEUP_PORTS*PREG_INDEX_WIDTH-1:0] pregs);
    logic hit;
    hit = 1'b0;
    for (int w = 0; w < WAKEUP_PORTS; w++) begin
      if (v[w] && (pregs[w*PREG_INDEX_WIDTH +: PREG_INDEX_WIDTH] == p)) hit = 1'b1;
    end
    return hit && (p != '0);
  endfunction

  function automatic complex_iq_dispatch_info_t apply_wakeup(
      input complex_iq_dispatch_info_t e,
      input logic [WAKEUP_PORTS-1:0] v,
      input logic [WAKEUP_PORTS*PREG_INDEX_WIDTH-1:0] pregs);
    complex_iq_dispatch_info_t r;
    r          = e;
    r.rj_ready = e.rj_ready | woken(e.preg_rj, v, pregs);
    r.rk_ready = e.rk_ready | woken(e.preg_rk, v, pregs);
    return r;
  endfunction

  function automatic complex_issue_queue_issued_info_t to_issued(input complex_iq_dispatch_info_t e);
    complex_issue_queue_issued_info_t r;
    r.rob_entry_index = e.rob_entry_index;
    r.preg_rj         = e.preg_rj;
    r.preg_rk         = e.preg_rk;
    r.preg_rd         = e.preg_rd;
    r.gen_op_type     = e.gen_op_type;
    r.spec_op_type    = e.spec_op_type;
    r.rd_exist        = e.rd_exist;
    return r;
  endfunction

  complex_iq_dispatch_info_t        entries_q [DEPTH];
  complex_iq_dispatch_info_t        entries_d [DEPTH];
  complex_iq_dispatch_info_t        new_entry;
  complex_issue_queue_issued_info_t issued_info_q;
  logic [DEPTH-1:0]                 valid_q, valid_d, rdy, sel_onehot;
  logic [IDX_W-1:0]                 sel_idx;
  logic [CNT_W-1:0]                 count_q, count_d, wr_slot;
  logic                             sel_valid, issue_fire, accept, shift, issue_valid_q;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      rdy[i] = valid_q[i] & entries_q[i].rj_ready & entries_q[i].rk_ready;
    end
  end

  ciq_select #(.DEPTH(DEPTH)) u_select (
    .ready_i  (rdy),
    .valid_o  (sel_valid),
    .onehot_o (sel_onehot),
    .idx_o    (sel_idx)
  );

  // Readiness of a new op also sees the wakeups broadcast in its dispatch cycle.
  always_comb begin
    new_entry          = dispatch_info;
    new_entry.rj_ready = dispatch_info.rj_ready | (dispatch_info.preg_rj == '0) |
                         woken(dispatch_info.preg_rj, wakeup_valid, wakeup_preg);
    new_entry.rk_ready = dispatch_info.rk_ready | (dispatch_info.preg_rk == '0) |
                         woken(dispatch_info.preg_rk, wakeup_valid, wakeup_preg);
  end

  assign dispatch_ready = (count_q < CNT_W'(DEPTH));
  assign accept         = dispatch_valid && dispatch_ready && !flush;
  assign issue_fire     = sel_valid && fu_ready && !flush;
  assign wr_slot        = issue_fire ? (count_q - CNT_W'(1)) : count_q;
  assign count_d        = flush ? '0 : (count_q + CNT_W'(accept) - CNT_W'(issue_fire));

  // Slots at and above the issued one collapse down by one.
  always_comb begin
    shift   = 1'b0;
    valid_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      shift = shift | (issue_fire & sel_onehot[i]);
      if (shift) begin
        if (i < DEPTH - 1) begin
          valid_d[i]   = valid_q[(i < DEPTH - 1) ? i + 1 : i];
          entries_d[i] = apply_wakeup(entries_q[(i < DEPTH - 1) ? i + 1 : i], wakeup_valid, wakeup_preg);
        end else begin
          valid_d[i]   = 1'b0;
          entries_d[i] = entries_q[i];
        end
      end else begin
        valid_d[i]   = valid_q[i];
        entries_d[i] = apply_wakeup(entries_q[i], wakeup_valid, wakeup_preg);
      end
      if (accept && (wr_slot == CNT_W'(i))) begin
        valid_d[i]   = 1'b1;
        entries_d[i] = new_entry;
      end
    end
    if (flush) valid_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q       <= '0;
      count_q       <= '0;
      issue_valid_q <= 1'b0;
      issued_info_q <= '0;
    end else begin
      valid_q       <= valid_d;
      count_q       <= count_d;
      issue_valid_q <= issue_fire;
      if (issue_fire) issued_info_q <= to_issued(entries_q[sel_idx]);
    end
  end

  always_ff @(posedge clk) begin
    entries_q <= entries_d;
  end

  assign issued_info = issued_info_q;
  assign issue_valid = issue_valid_q;
  assign iq_count    = count_q;

`ifdef COMPLEX_IQ_PERF_CNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] c);
    return (&c) ? c : (c + 32'd1);
  endfunction

  logic [31:0] perf_full_q, perf_issue_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_full_q  <= '0;
      perf_issue_q <= '0;
    end else begin
      if (count_q == CNT_W'(DEPTH)) perf_full_q <= sat_inc(perf_full_q);
      if (issue_fire)               perf_issue_q <= sat_inc(perf_issue_q);
    end
  end

  assign perf_full_cycles = perf_full_q;
  assign perf_issue_cnt   = perf_issue_q;
`endif

endmodule

// File: tb/tb_complex_issue_queue.sv
// Directed self-checking bench for complex_issue_queue.
module tb_complex_issue_queue;
  import complex_issue_queue_pkg::*;

  localparam int DEPTH = 8;
  localparam int WP    = 4;

  logic                             clk;
  logic                             rst_n;
  logic                             flush;
  logic                             dispatch_valid;
  logic                             dispatch_ready;
  complex_iq_dispatch_info_t        dispatch_info;
  logic [WP-1:0]                    wakeup_valid;
  logic [WP*PREG_INDEX_WIDTH-1:0]   wakeup_preg;
  logic                             fu_ready;
  complex_issue_queue_issued_info_t issued_info;
  logic                             issue_valid;
  logic [$clog2(DEPTH+1)-1:0]       iq_count;
`ifdef COMPLEX_IQ_PERF_CNT_EN
  logic [31:0] perf_full_cycles, perf_issue_cnt;
`endif

  int total = 0;
  int bad   = 0;

  complex_issue_queue #(.DEPTH(DEPTH), .WAKEUP_PORTS(WP)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush          (flush),
    .dispatch_valid (dispatch_valid),
    .dispatch_ready (dispatch_ready),
    .dispatch_info  (dispatch_info),
    .wakeup_valid   (wakeup_valid),
    .wakeup_preg    (wakeup_preg),
    .fu_ready       (fu_ready),
    .issued_info    (issued_info),
    .issue_valid    (issue_valid),
    .iq_count       (iq_count)
`ifdef COMPLEX_IQ_PERF_CNT_EN
    ,
    .perf_full_cycles (perf_full_cycles),
    .perf_issue_cnt   (perf_issue_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic complex_iq_dispatch_info_t mk(input int rob, input int rj, input int rk,
                                                   input bit rjr, input bit rkr, input bit rde);
    complex_iq_dispatch_info_t r;
    r.rob_entry_index = ROB_ENTRY_INDEX_WIDTH'(rob);
    r.preg_rj         = PREG_INDEX_WIDTH'(rj);
    r.preg_rk         = PREG_INDEX_WIDTH'(rk);
    r.preg_rd         = PREG_INDEX_WIDTH'(rob + 1);
    r.rj_ready        = rjr;
    r.rk_ready        = rkr;
    r.rd_exist        = rde;
    r.gen_op_type     = GENERAL_OPTYPE_DIV;
    r.spec_op_type    = _3R_MOD_W;
    return r;
  endfunction

  task automatic dispatch(input complex_iq_dispatch_info_t info);
    dispatch_valid = 1'b1;
    dispatch_info  = info;
  endtask

  task automatic set_wake(input int base, input int n);
    wakeup_valid = '0;
    wakeup_preg  = '0;
    for (int w = 0; w < n; w++) begin
      wakeup_valid[w] = 1'b1;
      wakeup_preg[w*PREG_INDEX_WIDTH +: PREG_INDEX_WIDTH] = PREG_INDEX_WIDTH'(base + w);
    end
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; dispatch_valid = 1'b0; dispatch_info = '0;
    wakeup_valid = '0; wakeup_preg = '0; fu_ready = 1'b1;
    tick(); tick();
    chk("rst_count", int'(iq_count), 0);
    chk("rst_issue_valid", int'(issue_valid), 0);
    chk("rst_dispatch_ready", int'(dispatch_ready), 1);
    chk("rst_issued_info", int'(issued_info == '0), 1);
    rst_n = 1'b1;
    tick();

    // single ready DIV: issue two edges after dispatch
    dispatch(mk(3, 5, 6, 1, 1, 1));
    tick();
    dispatch_valid = 1'b0;
    chk("t1_count_after_disp", int'(iq_count), 1);
    chk("t1_no_issue_yet", int'(issue_valid), 0);
    tick();
    chk("t1_issue_valid", int'(issue_valid), 1);
    chk("t1_rob", int'(issued_info.rob_entry_index), 3);
    chk("t1_rj", int'(issued_info.preg_rj), 5);
    chk("t1_rk", int'(issued_info.preg_rk), 6);
    chk("t1_rd", int'(issued_info.preg_rd), 4);
    chk("t1_gen_op", int'(issued_info.gen_op_type), int'(GENERAL_OPTYPE_DIV));
    chk("t1_spec_op", int'(issued_info.spec_op_type), int'(_3R_MOD_W));
    chk("t1_count_zero", int'(iq_count), 0);
    tick();
    chk("t1_empty_valid_low", int'(issue_valid), 0);
    chk("t1_info_held", int'(issued_info.rob_entry_index), 3);

    // A waits on preg 7, younger B ready: B first, then A
    dispatch(mk(10, 7, 0, 0, 0, 1));
    tick();
    dispatch(mk(11, 1, 2, 1, 1, 1));
    tick();
    dispatch_valid = 1'b0;
    chk("t2_no_issue_A_blocked", int'(issue_valid), 0);
    chk("t2_count2", int'(iq_count), 2);
    set_wake(7, 1);
    tick();
    set_wake(0, 0);
    chk("t2_B_issue_valid", int'(issue_valid), 1);
    chk("t2_B_first", int'(issued_info.rob_entry_index), 11);
    tick();
    chk("t2_A_issue_valid", int'(issue_valid), 1);
    chk("t2_A_second", int'(issued_info.rob_entry_index), 10);
    chk("t2_count0", int'(iq_count), 0);
    tick();

    // same-cycle wakeup of dispatching op's source; rd_exist=0 carried through
    dispatch(mk(20, 9, 0, 0, 0, 0));
    set_wake(9, 1);
    tick();
    dispatch_valid = 1'b0;
    set_wake(0, 0);
    chk("t3_not_yet", int'(issue_valid), 0);
    tick();
    chk("t3_issue_valid", int'(issue_valid), 1);
    chk("t3_rob", int'(issued_info.rob_entry_index), 20);
    chk("t3_rd_exist0", int'(issued_info.rd_exist), 0);
    tick();

    // fill with 8 blocked ops, reject 9th, wake all, drain in order
    for (int i = 0; i < DEPTH; i++) begin
      dispatch(mk(30 + i, 40 + i, 0, 0, 0, 1));
      tick();
    end
    chk("t4_full_count", int'(iq_count), 8);
    chk("t4_full_not_ready", int'(dispatch_ready), 0);
    chk("t4_none_issued", int'(issue_valid), 0);
    dispatch(mk(50, 1, 2, 1, 1, 1));
    tick();
    chk("t4_9th_rejected", int'(iq_count), 8);
    set_wake(40, 4);
    tick();
    chk("t4_still_full", int'(iq_count), 8);
    set_wake(44, 4);
    tick();
    set_wake(0, 0);
    dispatch_valid = 1'b0;
    chk("t4_first_valid", int'(issue_valid), 1);
    chk("t4_first_rob", int'(issued_info.rob_entry_index), 30);
    chk("t4_full_issue_no_accept", int'(iq_count), 7);
    chk("t4_ready_returns", int'(dispatch_ready), 1);
    for (int k = 1; k < DEPTH; k++) begin
      tick();
      chk($sformatf("t4_valid_%0d", k), int'(issue_valid), 1);
      chk($sformatf("t4_rob_%0d", k), int'(issued_info.rob_entry_index), 30 + k);
    end
    chk("t4_drained", int'(iq_count), 0);
    tick();
    chk("t4_valid_low", int'(issue_valid), 0);

    // fu_ready stall with 3 ready ops, then in-order release
    fu_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      dispatch(mk(60 + i, 1, 2, 1, 1, 1));
      tick();
    end
    dispatch_valid = 1'b0;
    tick();
    chk("t5_stalled_valid", int'(issue_valid), 0);
    chk("t5_stalled_count", int'(iq_count), 3);
    fu_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("t5_rob_%0d", k), int'(issued_info.rob_entry_index), 60 + k);
      chk($sformatf("t5_valid_%0d", k), int'(issue_valid), 1);
    end
    chk("t5_count0", int'(iq_count), 0);

    // flush with 5 ready entries and a simultaneous dispatch
    fu_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      dispatch(mk(1 + i, 1, 2, 1, 1, 1));
      tick();
    end
    chk("t6_count5", int'(iq_count), 5);
    dispatch(mk(40, 1, 2, 1, 1, 1));
    fu_ready = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    dispatch_valid = 1'b0;
    chk("t6_flush_count", int'(iq_count), 0);
    chk("t6_flush_valid", int'(issue_valid), 0);
    chk("t6_flush_ready", int'(dispatch_ready), 1);
    tick();
    chk("t6_dropped_valid", int'(issue_valid), 0);
    chk("t6_dropped_count", int'(iq_count), 0);

    // async reset mid-operation
    fu_ready = 1'b1;
    dispatch(mk(22, 1, 2, 1, 1, 1));
    tick();
    dispatch_valid = 1'b0;
    tick();
    chk("t7_pre_reset_valid", int'(issue_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t7_async_valid", int'(issue_valid), 0);
    chk("t7_async_count", int'(iq_count), 0);
    chk("t7_async_info", int'(issued_info == '0), 1);
    tick();
    rst_n = 1'b1;
    tick();
    chk("t7_after_reset_ready", int'(dispatch_ready), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
